// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with a per-slot blanking gap.
// Digit/dp registers load through a simple write port; all display outputs are registered.
module seven_seg_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic [3:0] blank_mask,
  input  logic       disp_en,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [3:0][3:0]  digit_r;
  logic [3:0]       dp_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_nxt_s;
  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic             wrap_s;
  logic             lit_s;

  // Active-low segment pattern {G..A} for a hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next scan position; state is recomputed from the next count so it always matches cnt_r.
  always_comb begin
    wrap_s      = (cnt_r == CNT_MAX);
    cnt_nxt_s   = cnt_r + CNT_ONE;
    idx_nxt_s   = idx_r;
    state_nxt_s = ST_BLANK;
    if (wrap_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      idx_nxt_s = idx_r;
    end
    if (cnt_nxt_s >= BLANK_LIM) begin
      state_nxt_s = ST_SHOW;
    end else begin
      state_nxt_s = ST_BLANK;
    end
    lit_s = (state_r == ST_SHOW) && disp_en && !blank_mask[idx_r];
  end

  // Digit and decimal-point storage, writable in any scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= 16'h0000;
      dp_r    <= 4'h0;
    end else if (wr_en) begin
      digit_r[wr_addr] <= wr_data;
      dp_r[wr_addr]    <= wr_dp;
    end
  end

  // Scan counter, digit index and blank/show state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= 2'd0;
      state_r <= ST_BLANK;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  // Registered display pins; anything not lit is driven fully dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 4'hF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (lit_s) begin
        an_n  <= ~(4'b0001 << idx_r);
        seg_n <= hex7(digit_r[idx_r]);
        dp_n  <= ~dp_r[idx_r];
      end else begin
        an_n  <= 4'hF;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end
      frame_tick <= wrap_s && (idx_r == 2'd3);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a short refresh period (8 clocks, 2 blank).
module tb_seven_seg_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic [3:0] blank_mask;
  logic       disp_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_tick;

  seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .blank_mask(blank_mask), .disp_en(disp_en), .seg_n(seg_n),
    .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;
  int ticks = 0;
  string stage = "init";

  logic [3:0] exp_dig [4];
  logic       exp_dp  [4];
  logic [3:0] exp_mask;
  logic       exp_en;
  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", stage, tag, got, exp);
    end
  endtask

  // Advance n edges; after each, compare all outputs with the expected scan position.
  task automatic run_check(input int n);
    for (int i = 0; i < n; i++) begin
      int p;
      int idx;
      int cnt;
      logic lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      @(posedge clk);
      edges++;
      @(negedge clk);
      p   = (edges - 1) % FRAME;
      idx = p / RD;
      cnt = p % RD;
      lit = exp_en && (cnt >= BC) && !exp_mask[idx];
      if (lit) begin
        e_an  = ~(4'b0001 << idx);
        e_seg = hex_tbl[exp_dig[idx]];
        e_dp  = ~exp_dp[idx];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end
      if (frame_tick) ticks++;
      check("an_n", 32'(an_n), 32'(e_an));
      check("seg_n", 32'(seg_n), 32'(e_seg));
      check("dp_n", 32'(dp_n), 32'(e_dp));
      check("frame_tick", 32'(frame_tick), 32'(p == FRAME - 1));
    end
  endtask

  // One-cycle write; the output on that edge still reflects the old digit.
  task automatic do_write(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    run_check(1);
    exp_dig[a] = d;
    exp_dp[a]  = p;
    wr_en = 1'b0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"}, 32'(an_n), 32'h0000000F);
    check({tag, "_seg"}, 32'(seg_n), 32'h0000007F);
    check({tag, "_dp"}, 32'(dp_n), 32'h00000001);
    check({tag, "_tick"}, 32'(frame_tick), 32'h00000000);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; wr_dp = 1'b0;
    blank_mask = 4'h0; disp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin exp_dig[i] = 4'h0; exp_dp[i] = 1'b0; end
    exp_mask = 4'h0; exp_en = 1'b1;

    // 1: reset and first lit digit on the third cycle
    stage = "reset";
    @(negedge clk); @(negedge clk);
    check_dark("in_reset");
    rst_n = 1'b1; edges = 0;
    run_check(3);
    check("first_an", 32'(an_n), 32'h0000000E);
    check("first_seg", 32'(seg_n), 32'h00000040);

    // 2: load 1,2,A(dp),F and scan a full frame
    stage = "scan";
    do_write(2'd0, 4'h1, 1'b0);
    do_write(2'd1, 4'h2, 1'b0);
    do_write(2'd2, 4'hA, 1'b1);
    do_write(2'd3, 4'hF, 1'b0);
    ticks = 0;
    run_check(FRAME);
    check("ticks_frame", 32'(ticks), 32'd1);

    // 3: mask digit 1, then disable whole display
    stage = "mask";
    blank_mask = 4'b0010; exp_mask = 4'b0010;
    run_check(FRAME);
    stage = "disp_off";
    disp_en = 1'b0; exp_en = 1'b0;
    ticks = 0;
    run_check(FRAME);
    check("ticks_off", 32'(ticks), 32'd1);
    blank_mask = 4'h0; exp_mask = 4'h0;
    disp_en = 1'b1; exp_en = 1'b1;

    // 4: write digit 0 while it is being shown
    stage = "live_wr";
    for (int g = 0; g < 2 * FRAME && (edges % FRAME) != 3; g++) run_check(1);
    check("align", 32'(edges % FRAME), 32'd3);
    do_write(2'd0, 4'h8, 1'b0);
    check("pre_seg", 32'(seg_n), 32'h00000079);
    check("pre_an", 32'(an_n), 32'h0000000E);
    run_check(1);
    check("post_seg", 32'(seg_n), 32'h00000000);
    check("post_an", 32'(an_n), 32'h0000000E);

    // 5: back-to-back writes, then reset in the middle of digit 2
    stage = "b2b";
    do_write(2'd0, 4'h3, 1'b1);
    do_write(2'd1, 4'h5, 1'b0);
    do_write(2'd2, 4'hC, 1'b1);
    do_write(2'd3, 4'hD, 1'b0);
    run_check(FRAME);
    for (int g = 0; g < 2 * FRAME && (edges % FRAME) != 20; g++) run_check(1);
    check("mid_d2_an", 32'(an_n), 32'h0000000B);
    check("mid_d2_seg", 32'(seg_n), 32'h00000046);
    check("mid_d2_dp", 32'(dp_n), 32'h00000000);
    stage = "mid_reset";
    rst_n = 1'b0;
    #1;
    check_dark("async");
    @(negedge clk); @(negedge clk);
    check_dark("held");
    rst_n = 1'b1; edges = 0;
    for (int i = 0; i < 4; i++) begin exp_dig[i] = 4'h0; exp_dp[i] = 1'b0; end
    run_check(3);
    check("restart_an", 32'(an_n), 32'h0000000E);
    check("restart_seg", 32'(seg_n), 32'h00000040);
    run_check(RD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
